// File: rtl/imem_boot_if.sv
// Boot/fetch bus of the instruction-memory boot controller: load control,
// program word stream, core fetch address and the instruction memory port.
interface imem_boot_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned LEN_W = ADDR_W + 1;

  logic              start_load;
  logic [LEN_W-1:0]  load_len;
  logic              run_req;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  logic [LEN_W-1:0]  words_left;

  // Boot link / core side: drives requests, stream words and fetch address.
  modport master (
    output start_load, load_len, run_req, s_valid, s_data, fetch_addr,
    input  s_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done,
           load_err, words_left
  );

  // Controller side.
  modport slave (
    input  start_load, load_len, run_req, s_valid, s_data, fetch_addr,
    output s_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done,
           load_err, words_left
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller: owns the single memory address port,
// streams a program into memory while the core is held in reset, then hands
// the port over to core fetch.
module imem_boot_ctrl #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  imem_boot_if.slave  bus
);
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic              core_hold_q, core_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              len_ok_c;
  logic              accept_c;
  logic [DATA_W-1:0] wdata_c;

  // Length qualification and stream handshake.
  always_comb begin
    len_ok_c = (bus.load_len != '0) && (bus.load_len <= LEN_W'(DEPTH));
    accept_c = bus.s_valid && (state_q == S_LOAD);
    wdata_c  = bus.s_data;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    words_left_d = words_left_q;
    load_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_load) begin
          if (len_ok_c) begin
            state_d      = S_LOAD;
            wr_ptr_d     = '0;
            words_left_d = bus.load_len;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (bus.run_req) begin
          state_d = S_RUN;
        end
      end

      S_LOAD: begin
        if (accept_c) begin
          words_left_d = words_left_q - LEN_W'(1);
          // Pointer stops on the last word so a full-depth load never wraps.
          if (words_left_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        if (bus.start_load) begin
          if (len_ok_c) begin
            state_d      = S_LOAD;
            wr_ptr_d     = '0;
            words_left_d = bus.load_len;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Core stays held until the cycle after DONE; done pulses while in DONE.
    core_hold_d = (state_d != S_RUN);
    load_done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      words_left_q <= '0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      words_left_q <= words_left_d;
      core_hold_q  <= core_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  // Memory port mux: loader owns the address only while loading.
  assign bus.s_ready    = (state_q == S_LOAD);
  assign bus.mem_we     = accept_c;
  assign bus.mem_wdata  = wdata_c;
  assign bus.mem_addr   = (state_q == S_LOAD) ? wr_ptr_q : bus.fetch_addr;

  assign bus.core_hold  = core_hold_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_err   = load_err_q;
  assign bus.words_left = words_left_q;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a write scoreboard.
module tb_imem_boot_ctrl;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  logic clk;
  logic rst;

  imem_boot_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+DATA_W-1:0] sb_q[$];
  logic [ADDR_W-1:0]        exp_ptr;
  logic [LEN_W-1:0]         exp_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Advance one clock; any write seen before the edge is scored.
  task automatic tick();
    logic [ADDR_W+DATA_W-1:0] e;
    #1;
    if (bus.mem_we === 1'b1) begin
      chk("write_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("write_addr", 32'(bus.mem_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        chk("write_data", bus.mem_wdata, e[DATA_W-1:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] len);
    bus.start_load = 1'b1;
    bus.load_len   = len;
    if (len != '0 && len <= LEN_W'(DEPTH)) begin
      exp_ptr  = '0;
      exp_left = len;
    end
    tick();
    bus.start_load = 1'b0;
  endtask

  // Offer one word after 'gap' idle cycles, checking words_left while waiting.
  task automatic send_word(input logic [DATA_W-1:0] data, input int gap);
    int n;
    bus.s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      settle();
      chk("gap_words_left", 32'(bus.words_left), 32'(exp_left));
      chk("gap_no_write", 32'(bus.mem_we), 32'd0);
      tick();
    end
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    sb_q.push_back({exp_ptr, data});
    settle();
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk("s_ready_seen", 32'(bus.s_ready), 32'd1);
    chk("words_left", 32'(bus.words_left), 32'(exp_left));
    tick();
    bus.s_valid = 1'b0;
    exp_ptr  = exp_ptr + ADDR_W'(1);
    exp_left = exp_left - LEN_W'(1);
  endtask

  // Checks the DONE cycle and the following first RUN cycle.
  task automatic check_done_then_run();
    settle();
    chk("done_pulse", 32'(bus.load_done), 32'd1);
    chk("done_hold", 32'(bus.core_hold), 32'd1);
    chk("done_no_ready", 32'(bus.s_ready), 32'd0);
    chk("done_no_write", 32'(bus.mem_we), 32'd0);
    chk("done_words_left", 32'(bus.words_left), 32'd0);
    tick();
    bus.s_valid = 1'b0;
    settle();
    chk("run_release", 32'(bus.core_hold), 32'd0);
    chk("run_done_low", 32'(bus.load_done), 32'd0);
  endtask

  task automatic bad_start(input logic [LEN_W-1:0] len, input logic exp_hold);
    do_start(len);
    settle();
    chk("err_pulse", 32'(bus.load_err), 32'd1);
    chk("err_hold", 32'(bus.core_hold), 32'(exp_hold));
    chk("err_no_ready", 32'(bus.s_ready), 32'd0);
    tick();
    chk("err_cleared", 32'(bus.load_err), 32'd0);
    chk("err_still_no_ready", 32'(bus.s_ready), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.start_load = 1'b0;
    bus.load_len   = '0;
    bus.run_req    = 1'b0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.fetch_addr = '0;
    exp_ptr        = '0;
    exp_left       = '0;

    // Reset state
    tick();
    tick();
    settle();
    chk("rst_hold", 32'(bus.core_hold), 32'd1);
    chk("rst_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_words_left", 32'(bus.words_left), 32'd0);
    chk("rst_done", 32'(bus.load_done), 32'd0);
    chk("rst_err", 32'(bus.load_err), 32'd0);
    rst = 1'b0;

    // Load of 4 back-to-back words
    do_start(LEN_W'(4));
    settle();
    chk("load_ready", 32'(bus.s_ready), 32'd1);
    chk("load_hold", 32'(bus.core_hold), 32'd1);
    for (int i = 0; i < 4; i++) send_word(32'hA0 + 32'(i), 0);
    check_done_then_run();

    // Fetch passthrough and ignored run_req in RUN
    bus.fetch_addr = 9'h1FF;
    bus.run_req    = 1'b1;
    settle();
    chk("fetch_pass", 32'(bus.mem_addr), 32'h1FF);
    tick();
    bus.run_req = 1'b0;
    settle();
    chk("run_req_ignored", 32'(bus.core_hold), 32'd0);

    // Invalid lengths in RUN
    bad_start(LEN_W'(0), 1'b0);
    bad_start(LEN_W'(513), 1'b0);

    // Load of 3 words with 2-cycle gaps; requests during LOAD are ignored
    do_start(LEN_W'(3));
    settle();
    chk("reload_hold", 32'(bus.core_hold), 32'd1);
    bus.start_load = 1'b1;
    bus.load_len   = LEN_W'(7);
    bus.run_req    = 1'b1;
    tick();
    bus.start_load = 1'b0;
    bus.run_req    = 1'b0;
    settle();
    chk("load_ignore_err", 32'(bus.load_err), 32'd0);
    chk("load_ignore_left", 32'(bus.words_left), 32'd3);
    for (int i = 0; i < 3; i++) send_word(32'hC0DE_0000 + 32'(i), 2);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEAD_BEEF;
    check_done_then_run();
    chk("fetch_after_load", 32'(bus.mem_addr), 32'h1FF);

    // Full-depth load from RUN
    do_start(LEN_W'(512));
    settle();
    chk("full_hold", 32'(bus.core_hold), 32'd1);
    chk("full_words_left", 32'(bus.words_left), 32'd512);
    for (int i = 0; i < 512; i++) send_word($urandom, 0);
    check_done_then_run();

    // Back to IDLE; invalid length in IDLE, then start_load beats run_req
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad_start(LEN_W'(0), 1'b1);
    bus.run_req = 1'b1;
    do_start(LEN_W'(4));
    bus.run_req = 1'b0;
    settle();
    chk("start_wins", 32'(bus.s_ready), 32'd1);
    send_word(32'hB000_0000, 0);
    send_word(32'hB000_0001, 0);

    // Reset mid-load aborts without load_done
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("abort_hold", 32'(bus.core_hold), 32'd1);
    chk("abort_ready", 32'(bus.s_ready), 32'd0);
    chk("abort_done", 32'(bus.load_done), 32'd0);
    chk("abort_words_left", 32'(bus.words_left), 32'd0);
    tick();
    chk("abort_done_later", 32'(bus.load_done), 32'd0);
    chk("abort_stays_idle", 32'(bus.core_hold), 32'd1);

    // run_req from IDLE releases core without a load
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    settle();
    chk("idle_run", 32'(bus.core_hold), 32'd0);
    chk("idle_run_no_done", 32'(bus.load_done), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
